// File: rtl/master_transmitter_if.sv
// Parallel/serial signal bundle between the SPI master stage and its neighbours.
// The master modport is the transmitter's view; the slave modport is the far side.
interface master_transmitter_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  start_transaction;
    logic                  CKP;
    logic                  CPH;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  MISO;
    logic                  SCK;
    logic                  MOSI;
    logic                  SS;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;

    modport master (
        input  start_transaction,
        input  CKP,
        input  CPH,
        input  tx_data,
        input  MISO,
        output SCK,
        output MOSI,
        output SS,
        output rx_data,
        output busy,
        output done
    );

    modport slave (
        output start_transaction,
        output CKP,
        output CPH,
        output tx_data,
        output MISO,
        input  SCK,
        input  MOSI,
        input  SS,
        input  rx_data,
        input  busy,
        input  done
    );
endinterface

// File: rtl/master_transmitter.sv
// SPI master: frames a parallel word onto SS/SCK/MOSI in any CKP/CPH mode and
// captures the MISO reply. SCK half-period is DIV system clocks.
module master_transmitter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DIV        = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    master_transmitter_if.master bus
);
    localparam int unsigned N         = DATA_WIDTH;
    localparam int unsigned HP_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned EDGE_W    = $clog2(2 * N + 1);
    localparam int unsigned LAST_EDGE = 2 * N - 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LEAD     = 2'd1,
        TRANSFER = 2'd2,
        TRAIL    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [HP_W-1:0]     hp_q, hp_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [N-1:0]        tx_q, tx_d;
    logic [N-1:0]        rx_q, rx_d;
    logic [N-1:0]        rxdata_q, rxdata_d;
    logic                ckp_q, ckp_d;
    logic                cph_q, cph_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                ss_q, ss_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                hp_wrap_c;
    logic                leading_c;
    logic                last_edge_c;

    // Odd-numbered toggles (edge count even before the toggle) move SCK away from idle.
    assign hp_wrap_c   = (hp_q == HP_W'(DIV - 1));
    assign leading_c   = ~edge_q[0];
    assign last_edge_c = (edge_q == EDGE_W'(LAST_EDGE));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            hp_q     <= '0;
            edge_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rxdata_q <= '0;
            ckp_q    <= 1'b0;
            cph_q    <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            ss_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hp_q     <= hp_d;
            edge_q   <= edge_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rxdata_q <= rxdata_d;
            ckp_q    <= ckp_d;
            cph_q    <= cph_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            ss_q     <= ss_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        edge_d   = edge_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rxdata_d = rxdata_q;
        ckp_d    = ckp_q;
        cph_d    = cph_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        ss_d     = ss_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                ss_d   = 1'b1;
                busy_d = 1'b0;
                sck_d  = bus.CKP;
                if (bus.start_transaction) begin
                    tx_d    = bus.tx_data;
                    rx_d    = '0;
                    ckp_d   = bus.CKP;
                    cph_d   = bus.CPH;
                    ss_d    = 1'b0;
                    mosi_d  = bus.CPH ? 1'b0 : bus.tx_data[N-1];
                    hp_d    = '0;
                    edge_d  = '0;
                    busy_d  = 1'b1;
                    state_d = LEAD;
                end
            end

            LEAD: begin
                if (hp_wrap_c) begin
                    hp_d    = '0;
                    state_d = TRANSFER;
                end else begin
                    hp_d = hp_q + HP_W'(1);
                end
            end

            TRANSFER: begin
                if (hp_wrap_c) begin
                    hp_d   = '0;
                    sck_d  = ~sck_q;
                    edge_d = edge_q + EDGE_W'(1);
                    // Mode 0/2 samples on leading and shifts on trailing; mode 1/3 the reverse.
                    if (!cph_q) begin
                        if (leading_c) begin
                            rx_d = {rx_q[N-2:0], bus.MISO};
                        end else if (!last_edge_c) begin
                            tx_d   = {tx_q[N-2:0], 1'b0};
                            mosi_d = tx_q[N-2];
                        end
                    end else begin
                        if (leading_c) begin
                            mosi_d = tx_q[N-1];
                            tx_d   = {tx_q[N-2:0], 1'b0};
                        end else begin
                            rx_d = {rx_q[N-2:0], bus.MISO};
                        end
                    end
                    if (last_edge_c) begin
                        state_d = TRAIL;
                    end
                end else begin
                    hp_d = hp_q + HP_W'(1);
                end
            end

            TRAIL: begin
                if (hp_wrap_c) begin
                    hp_d     = '0;
                    edge_d   = '0;
                    ss_d     = 1'b1;
                    rxdata_d = rx_q;
                    done_d   = 1'b1;
                    mosi_d   = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    hp_d = hp_q + HP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.SCK     = sck_q;
    assign bus.MOSI    = mosi_q;
    assign bus.SS      = ss_q;
    assign bus.rx_data = rxdata_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_master_transmitter.sv
// Randomised bench for master_transmitter: an SCK-edge-driven slave model that
// shifts a reply word out and collects MOSI, plus frame-level timing expectations.
module tb_master_transmitter;
    localparam int unsigned N   = 16;
    localparam int unsigned DIV = 2;
    localparam int          LAT = (2 * N + 2) * DIV;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    master_transmitter_if #(.DATA_WIDTH(N)) bus ();

    master_transmitter #(.DATA_WIDTH(N), .DIV(DIV)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int nvec = 0;
    int nerr = 0;

    // Slave model state: mode it believes is in force, word it returns, word it received.
    logic         mon_ckp = 1'b0;
    logic         mon_cph = 1'b0;
    logic         loopback = 1'b0;
    logic [N-1:0] slave_word = '0;
    logic [N-1:0] slave_rx = '0;
    int           leads = 0;
    int           rises = 0;
    int           mosi_bad = 0;
    logic         ss_prev = 1'b1;
    logic         sck_prev = 1'b0;
    logic         mosi_prev = 1'b0;

    always @(negedge CLK) begin
        logic lead;
        int   idx;
        if (ss_prev && !bus.SS) begin
            leads    = 0;
            rises    = 0;
            mosi_bad = 0;
            slave_rx = '0;
        end
        lead = 1'b0;
        if (!bus.SS && !ss_prev && (bus.SCK !== sck_prev)) begin
            lead = (bus.SCK != mon_ckp);
            if (bus.SCK) rises++;
            if (lead) leads++;
            if (lead != mon_cph) slave_rx = {slave_rx[N-2:0], bus.MOSI};
        end
        // MOSI may only move together with an SCK toggle on the slave's shift edge.
        if (!bus.SS && !ss_prev && (bus.MOSI !== mosi_prev)) begin
            if (!((bus.SCK !== sck_prev) && (lead == mon_cph))) mosi_bad++;
        end
        if (loopback) begin
            bus.MISO = bus.MOSI;
        end else begin
            idx = mon_cph ? leads - 1 : leads;
            if (idx >= 0 && idx < int'(N)) bus.MISO = slave_word[N-1-idx];
            else bus.MISO = 1'b0;
        end
        ss_prev   = bus.SS;
        sck_prev  = bus.SCK;
        mosi_prev = bus.MOSI;
    end

    // Launch one frame and wait for done; optional mid-frame input change or reset.
    task automatic do_frame(input logic ckp, input logic cph, input logic [N-1:0] tx,
                            input logic [N-1:0] sw, input logic lb, input int chg_at,
                            input int rst_at, output int lat);
        int n;
        @(negedge CLK);
        mon_ckp    = ckp;
        mon_cph    = cph;
        slave_word = sw;
        loopback   = lb;
        bus.CKP    = ckp;
        bus.CPH    = cph;
        bus.tx_data = tx;
        bus.start_transaction = 1'b1;
        lat = -1;
        n   = 0;
        @(negedge CLK);
        bus.start_transaction = 1'b0;
        while (n < 4 * LAT) begin
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
            if (rst_at > 0 && n == rst_at) return;
            if (rst_at > 0 && n == rst_at - 1) RESET = 1'b1;
            if (chg_at > 0 && n == chg_at) begin
                bus.CKP = ~ckp;
                bus.CPH = ~cph;
                bus.tx_data = ~tx;
                bus.start_transaction = 1'b1;
            end
            if (chg_at > 0 && n == chg_at + 1) bus.start_transaction = 1'b0;
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic set_idle(input logic ckp);
        @(negedge CLK);
        bus.CKP = ckp;
        mon_ckp = ckp;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset;
        bus.start_transaction = 1'b0;
        bus.CKP = 1'b0;
        bus.CPH = 1'b0;
        bus.tx_data = '0;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        nvec++; if (bus.SS !== 1'b1) begin nerr++; $display("FAIL reset_ss: got %b want 1", bus.SS); end
        nvec++; if (bus.SCK !== 1'b0) begin nerr++; $display("FAIL reset_sck: got %b want 0", bus.SCK); end
        nvec++; if (bus.MOSI !== 1'b0) begin nerr++; $display("FAIL reset_mosi: got %b want 0", bus.MOSI); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", bus.done); end
        nvec++; if (bus.rx_data !== '0) begin nerr++; $display("FAIL reset_rx: got %h want 0", bus.rx_data); end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid;
        int lat;
        int dones;
        logic [N-1:0] tx;
        logic [N-1:0] sw;
        tx = N'($urandom);
        sw = N'($urandom) | N'(1);
        do_frame(1'b0, 1'b0, tx, sw, 1'b0, 0, 20, lat);
        nvec++; if (bus.SS !== 1'b1) begin nerr++; $display("FAIL midrst_ss: got %b want 1", bus.SS); end
        nvec++; if (bus.SCK !== 1'b0) begin nerr++; $display("FAIL midrst_sck: got %b want 0", bus.SCK); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        nvec++; if (bus.MOSI !== 1'b0) begin nerr++; $display("FAIL midrst_mosi: got %b want 0", bus.MOSI); end
        RESET = 1'b0;
        dones = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge CLK);
            if (bus.done === 1'b1) dones++;
        end
        nvec++; if (dones != 0) begin nerr++; $display("FAIL midrst_done: got %0d pulses want 0", dones); end
        nvec++; if (bus.rx_data !== '0) begin nerr++; $display("FAIL midrst_rx: got %h want 0", bus.rx_data); end
    endtask

    task automatic test_mode0_loopback;
        int lat;
        set_idle(1'b0);
        do_frame(1'b0, 1'b0, 16'hA5C3, '0, 1'b1, 0, 0, lat);
        nvec++; if (lat != LAT) begin nerr++; $display("FAIL m0_latency: got %0d want %0d", lat, LAT); end
        nvec++; if (bus.rx_data !== 16'hA5C3) begin nerr++; $display("FAIL m0_rx: got %h want a5c3", bus.rx_data); end
        nvec++; if (slave_rx !== 16'hA5C3) begin nerr++; $display("FAIL m0_mosi_bits: got %b want 1010010111000011", slave_rx); end
        nvec++; if (rises != int'(N)) begin nerr++; $display("FAIL m0_rises: got %0d want %0d", rises, N); end
        nvec++; if (mosi_bad != 0) begin nerr++; $display("FAIL m0_mosi_edge: got %0d bad changes want 0", mosi_bad); end
        nvec++; if (bus.busy !== 1'b0 || bus.SS !== 1'b1) begin nerr++; $display("FAIL m0_end: got busy=%b ss=%b want 0/1", bus.busy, bus.SS); end
        @(negedge CLK);
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL m0_done_width: got %b want 0", bus.done); end
    endtask

    task automatic test_mode3;
        int lat;
        set_idle(1'b1);
        nvec++; if (bus.SCK !== 1'b1) begin nerr++; $display("FAIL m3_idle_pre: got %b want 1", bus.SCK); end
        do_frame(1'b1, 1'b1, 16'h1234, 16'h0402, 1'b0, 0, 0, lat);
        nvec++; if (lat != LAT) begin nerr++; $display("FAIL m3_latency: got %0d want %0d", lat, LAT); end
        nvec++; if (bus.rx_data !== 16'h0402) begin nerr++; $display("FAIL m3_rx: got %h want 0402", bus.rx_data); end
        nvec++; if (slave_rx !== 16'h1234) begin nerr++; $display("FAIL m3_slave_rx: got %h want 1234", slave_rx); end
        nvec++; if (leads != int'(N)) begin nerr++; $display("FAIL m3_leads: got %0d want %0d", leads, N); end
        @(negedge CLK);
        nvec++; if (bus.SCK !== 1'b1) begin nerr++; $display("FAIL m3_idle_post: got %b want 1", bus.SCK); end
    endtask

    task automatic test_modes12;
        int lat;
        logic ckp, cph;
        logic [N-1:0] tx, sw;
        for (int m = 0; m < 2; m++) begin
            ckp = (m == 1);
            cph = (m == 0);
            for (int w = 0; w < 2; w++) begin
                tx = (w == 0) ? 16'hFFFF : 16'h0000;
                sw = N'($urandom);
                set_idle(ckp);
                nvec++; if (bus.SCK !== ckp) begin nerr++; $display("FAIL m12_idle_pre: mode %0d got %b want %b", m + 1, bus.SCK, ckp); end
                do_frame(ckp, cph, tx, sw, 1'b0, 0, 0, lat);
                nvec++; if (bus.rx_data !== sw) begin nerr++; $display("FAIL m12_rx: mode %0d got %h want %h", m + 1, bus.rx_data, sw); end
                nvec++; if (slave_rx !== tx) begin nerr++; $display("FAIL m12_slave_rx: mode %0d got %h want %h", m + 1, slave_rx, tx); end
                nvec++; if (mosi_bad != 0) begin nerr++; $display("FAIL m12_mosi_edge: mode %0d got %0d want 0", m + 1, mosi_bad); end
                nvec++; if (bus.SCK !== ckp) begin nerr++; $display("FAIL m12_idle_post: mode %0d got %b want %b", m + 1, bus.SCK, ckp); end
            end
        end
    endtask

    task automatic test_random;
        int lat;
        logic ckp, cph;
        logic [N-1:0] tx, sw;
        for (int i = 0; i < 6; i++) begin
            ckp = 1'($urandom);
            cph = 1'($urandom);
            tx  = N'($urandom);
            sw  = N'($urandom);
            set_idle(ckp);
            do_frame(ckp, cph, tx, sw, 1'b0, 0, 0, lat);
            nvec++; if (lat != LAT) begin nerr++; $display("FAIL rnd_latency: iter %0d got %0d want %0d", i, lat, LAT); end
            nvec++; if (bus.rx_data !== sw) begin nerr++; $display("FAIL rnd_rx: iter %0d got %h want %h", i, bus.rx_data, sw); end
            nvec++; if (slave_rx !== tx) begin nerr++; $display("FAIL rnd_slave_rx: iter %0d got %h want %h", i, slave_rx, tx); end
            nvec++; if (rises != int'(N)) begin nerr++; $display("FAIL rnd_rises: iter %0d got %0d want %0d", i, rises, N); end
            nvec++; if (mosi_bad != 0) begin nerr++; $display("FAIL rnd_mosi_edge: iter %0d got %0d want 0", i, mosi_bad); end
        end
    endtask

    task automatic test_ignore_changes;
        int lat;
        logic [N-1:0] tx, sw;
        tx = N'($urandom);
        sw = N'($urandom);
        set_idle(1'b0);
        do_frame(1'b0, 1'b1, tx, sw, 1'b0, 10, 0, lat);
        nvec++; if (lat != LAT) begin nerr++; $display("FAIL ign_latency: got %0d want %0d", lat, LAT); end
        nvec++; if (bus.rx_data !== sw) begin nerr++; $display("FAIL ign_rx: got %h want %h", bus.rx_data, sw); end
        nvec++; if (slave_rx !== tx) begin nerr++; $display("FAIL ign_slave_rx: got %h want %h", slave_rx, tx); end
        nvec++; if (mosi_bad != 0) begin nerr++; $display("FAIL ign_mosi_edge: got %0d want 0", mosi_bad); end
        repeat (3) @(negedge CLK);
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL ign_start: got busy=%b want 0", bus.busy); end
        bus.CKP = 1'b0;
        bus.CPH = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        int t[3];
        logic [N-1:0] tx;
        tx = N'($urandom);
        set_idle(1'b0);
        @(negedge CLK);
        mon_ckp = 1'b0;
        mon_cph = 1'b0;
        loopback = 1'b1;
        bus.CPH = 1'b0;
        bus.tx_data = tx;
        bus.start_transaction = 1'b1;
        n = 0;
        for (int f = 0; f < 3; f++) begin
            t[f] = -1;
            while (bus.done !== 1'b1 && n < 8 * LAT) begin
                @(negedge CLK);
                n++;
            end
            if (bus.done === 1'b1) t[f] = n;
            nvec++; if (bus.rx_data !== tx) begin nerr++; $display("FAIL b2b_rx: frame %0d got %h want %h", f, bus.rx_data, tx); end
            if (f == 2) begin
                bus.start_transaction = 1'b0;
            end else begin
                nvec++; if (bus.SS !== 1'b1) begin nerr++; $display("FAIL b2b_ss_high: frame %0d got %b want 1", f, bus.SS); end
                @(negedge CLK);
                n++;
                nvec++; if (bus.SS !== 1'b0) begin nerr++; $display("FAIL b2b_ss_gap: frame %0d got %b want 0", f, bus.SS); end
            end
        end
        nvec++; if (t[1] - t[0] != LAT + 1) begin nerr++; $display("FAIL b2b_spacing1: got %0d want %0d", t[1] - t[0], LAT + 1); end
        nvec++; if (t[2] - t[1] != LAT + 1) begin nerr++; $display("FAIL b2b_spacing2: got %0d want %0d", t[2] - t[1], LAT + 1); end
        repeat (4) @(negedge CLK);
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL b2b_stop: got busy=%b want 0", bus.busy); end
        loopback = 1'b0;
    endtask

    initial begin
        bus.start_transaction = 1'b0;
        bus.CKP = 1'b0;
        bus.CPH = 1'b0;
        bus.tx_data = '0;
        test_reset();
        test_reset_mid();
        test_mode0_loopback();
        test_mode3();
        test_modes12();
        test_random();
        test_ignore_changes();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
